// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: bus widths, reset PC default,
// FSM state encoding and the fetch-queue entry layout.
package fetch_unit_pkg;

  typedef logic [31:0] AddressBus;
  typedef logic [31:0] InstBus;

  localparam AddressBus RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } fetch_state_e;

  typedef struct packed {
    InstBus    inst;
    AddressBus pc;
    logic      taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: i-cache request/response, predictor lookup,
// decode-side queue head handshake and commit redirect.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic      icache_req_out;
  AddressBus icache_addr_out;
  logic      icache_ack_in;
  InstBus    icache_inst_in;
  AddressBus pred_pc_out;
  AddressBus pred_next_pc_in;
  logic      pred_taken_in;
  logic      inst_valid_out;
  InstBus    inst_out;
  AddressBus inst_pc_out;
  logic      inst_pred_taken_out;
  logic      inst_ready_in;
  logic      flush_in;
  AddressBus flush_pc_in;

  modport master (
    output icache_req_out, icache_addr_out, pred_pc_out,
           inst_valid_out, inst_out, inst_pc_out, inst_pred_taken_out,
    input  icache_ack_in, icache_inst_in, pred_next_pc_in, pred_taken_in,
           inst_ready_in, flush_in, flush_pc_in
  );

  modport slave (
    input  icache_req_out, icache_addr_out, pred_pc_out,
           inst_valid_out, inst_out, inst_pc_out, inst_pred_taken_out,
    output icache_ack_in, icache_inst_in, pred_next_pc_in, pred_taken_in,
           inst_ready_in, flush_in, flush_pc_in
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: circular buffer of fetched instructions; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IW    = $clog2(DEPTH),
  localparam int unsigned PTR_W = IW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fq_entry_t        i_data,
  output fq_entry_t        o_head,
  output logic [PTR_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  fq_entry_t        r_mem [DEPTH];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head <= '0;
      r_tail <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail[IW-1:0]] <= i_data;
        r_tail                <= r_tail + PTR_W'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
    end
  end

  assign o_head  = r_mem[r_head[IW-1:0]];
  assign o_count = r_tail - r_head;
  assign o_full  = (o_count == PTR_W'(DEPTH));
  assign o_empty = (r_head == r_tail);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one i-cache request in
// flight and buffers results for decode. FETCH_PREDICT_EN enables predictor use.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter AddressBus   RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e r_state, w_state_n;
  AddressBus    r_pc, w_pc_n;
  AddressBus    r_addr, w_addr_n;
  logic         r_req, w_req_n;
  logic         w_push, w_pop, w_qflush;
  fq_entry_t    w_push_data, w_head;
  logic [CW-1:0] w_count, w_count_after_ack;
  logic         w_full, w_empty;
  AddressBus    w_next_pc;
  logic         w_taken;

`ifdef FETCH_PREDICT_EN
  assign w_next_pc = bus.pred_next_pc_in;
  assign w_taken   = bus.pred_taken_in;
`else
  logic w_unused_pred;
  assign w_next_pc     = r_addr + 32'd4;
  assign w_taken       = 1'b0;
  assign w_unused_pred = ^{bus.pred_next_pc_in, bus.pred_taken_in};
`endif

  assign w_pop             = ~w_empty & bus.inst_ready_in & ~bus.flush_in;
  assign w_count_after_ack = w_count + CW'(1) - CW'(w_pop);
  assign w_push_data       = '{inst: bus.icache_inst_in, pc: r_addr, taken: w_taken};

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_push & rdy_in),
    .i_pop   (w_pop & rdy_in),
    .i_flush (w_qflush & rdy_in),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_req_n   = r_req;
    w_addr_n  = r_addr;
    w_push    = 1'b0;
    w_qflush  = 1'b0;
    if (bus.flush_in) begin
      w_qflush = 1'b1;
      w_pc_n   = bus.flush_pc_in;
      // An issued request must still complete; its ack is absorbed in DROP.
      if (r_state != ST_IDLE) begin
        if (bus.icache_ack_in) begin
          w_req_n   = 1'b0;
          w_state_n = ST_IDLE;
        end else begin
          w_state_n = ST_DROP;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_full) begin
            w_req_n   = 1'b1;
            w_addr_n  = r_pc;
            w_state_n = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.icache_ack_in) begin
            w_push = 1'b1;
            w_pc_n = w_next_pc;
            if (w_count_after_ack < CW'(QUEUE_DEPTH)) begin
              w_addr_n = w_next_pc;
            end else begin
              w_req_n   = 1'b0;
              w_state_n = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (bus.icache_ack_in) begin
            w_req_n   = 1'b0;
            w_state_n = ST_IDLE;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else if (rdy_in) begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_req   <= w_req_n;
      r_addr  <= w_addr_n;
    end
  end

  assign bus.icache_req_out      = r_req;
  assign bus.icache_addr_out     = r_addr;
  assign bus.pred_pc_out         = r_pc;
  assign bus.inst_valid_out      = ~w_empty;
  assign bus.inst_out            = w_head.inst;
  assign bus.inst_pc_out         = w_head.pc;
  assign bus.inst_pred_taken_out = w_head.taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the expected instruction stream is derived
// from the program-order fetch rule (next = predicted or +4, restart on flush).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  fetch_unit_if bus();

  fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_cmp  = 0;
  int unsigned n_err  = 0;
  int unsigned n_pops = 0;
  logic [31:0] m_pc;
  bit          m_stale;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic bp_taken(input logic [31:0] a);
    return a[4:0] == 5'h08;
  endfunction

  function automatic logic [31:0] bp_target(input logic [31:0] a);
    return (a & 32'hFFFF_FF00) + 32'h100;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a);
`ifdef FETCH_PREDICT_EN
    return bp_taken(a) ? bp_target(a) : a + 32'd4;
`else
    return a + 32'd4;
`endif
  endfunction

  function automatic logic model_taken(input logic [31:0] a);
`ifdef FETCH_PREDICT_EN
    return bp_taken(a);
`else
    return 1'b0;
`endif
  endfunction

  // Predictor and cache memory respond combinationally to the DUT's addresses.
  always_comb begin
    bus.pred_taken_in   = bp_taken(bus.pred_pc_out);
    bus.pred_next_pc_in = bp_taken(bus.pred_pc_out) ? bp_target(bus.pred_pc_out)
                                                     : bus.pred_pc_out + 32'd4;
    bus.icache_inst_in  = mem_word(bus.icache_addr_out);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the queue head whenever decode takes it.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("valid", 32'(bus.inst_valid_out), 32'(exp_q.size() != 0));
      if (rdy && bus.inst_valid_out && bus.inst_ready_in && !bus.flush_in) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", bus.inst_pc_out, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_inst", bus.inst_out, mon_e.inst);
          check("pop_pc", bus.inst_pc_out, mon_e.pc);
          check("pop_taken", 32'(bus.inst_pred_taken_out), 32'(mon_e.taken));
          n_pops++;
        end
      end
    end
  end

  // Reference model: accepted acks append the next program-order fetch.
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && rdy) begin
      if (bus.flush_in) begin
        exp_q.delete();
        m_stale = bus.icache_req_out && !bus.icache_ack_in;
        m_pc    = bus.flush_pc_in;
      end else if (bus.icache_req_out && bus.icache_ack_in) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          check("ack_addr", bus.icache_addr_out, m_pc);
          check("room", 32'(exp_q.size() < DEPTH), 32'd1);
          exp_q.push_back('{mem_word(m_pc), m_pc, model_taken(m_pc)});
          m_pc = model_next(m_pc);
        end
      end
    end
  end

  task automatic cyc(input bit a_en, input bit rd, input bit fl, input logic [31:0] fpc, input bit rv);
    bus.icache_ack_in = a_en & bus.icache_req_out;
    bus.inst_ready_in = rd;
    bus.flush_in      = fl;
    bus.flush_pc_in   = fpc;
    rdy               = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (bus.icache_req_out) seen = 1'b1;
      else cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int unsigned p0;
    logic [31:0] rnd;
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.icache_ack_in = 1'b0;
    bus.inst_ready_in = 1'b0;
    bus.flush_in      = 1'b0;
    bus.flush_pc_in   = 32'h0;
    m_pc    = RST_PC;
    m_stale = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.icache_req_out), 32'd0);
    check("rst_addr", bus.icache_addr_out, 32'h0);
    check("rst_valid", 32'(bus.inst_valid_out), 32'd0);
    check("rst_inst", bus.inst_out, 32'h0);
    check("rst_inst_pc", bus.inst_pc_out, 32'h0);
    check("rst_taken", 32'(bus.inst_pred_taken_out), 32'd0);
    check("rst_pred_pc", bus.pred_pc_out, RST_PC);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_req", 32'(bus.icache_req_out), 32'd1);
    check("first_addr", bus.icache_addr_out, RST_PC);

    p0 = n_pops;
    repeat (40) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("throughput", 32'((n_pops - p0) >= 38), 32'd1);

    repeat (12) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("full_req", 32'(bus.icache_req_out), 32'd0);
    check("full_valid", 32'(bus.inst_valid_out), 32'd1);
    check("full_count", 32'(exp_q.size()), DEPTH);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    bus.inst_ready_in = 1'b0;
    wait_req("req_reassert");

    cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    check("drop_valid", 32'(bus.inst_valid_out), 32'd0);
    check("drop_req_held", 32'(bus.icache_req_out), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    wait_req("drop_rereq");
    check("drop_target", bus.icache_addr_out, 32'h200);

    repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    check("coinc_valid", 32'(bus.inst_valid_out), 32'd0);
    check("coinc_req", 32'(bus.icache_req_out), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("coinc_rereq", 32'(bus.icache_req_out), 32'd1);
    check("coinc_target", bus.icache_addr_out, 32'h200);

    repeat (5) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    repeat (3000) begin
      rnd = $urandom();
      if (rnd[3:0] == 4'h0) rnd = 32'hFFFF_FFF0;
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
          $urandom_range(0, 99) < 4, {rnd[31:2], 2'b00}, $urandom_range(0, 9) != 0);
    end

    bus.inst_ready_in = 1'b0;
    wait_req("midrst_prereq");
    bus.icache_ack_in = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    m_pc    = RST_PC;
    m_stale = 1'b0;
    #1;
    check("midrst_req", 32'(bus.icache_req_out), 32'd0);
    check("midrst_addr", bus.icache_addr_out, 32'h0);
    check("midrst_valid", 32'(bus.inst_valid_out), 32'd0);
    check("midrst_inst_pc", bus.inst_pc_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("drain_valid", 32'(bus.inst_valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly in front of the branch predictor and feeds decode. It owns the architectural fetch PC and issues one instruction-cache request at a time. It presents the PC to the predictor to obtain the next fetch address. Fetched instructions are buffered, with their PC and predicted-taken bit, in a small queue that the decoder drains with a valid/ready handshake. Commit-stage redirects (flush) discard queued and in-flight work.

## Interface
- QUEUE_DEPTH, 4, fetch-queue entries; power of two, ≥2
- RESET_PC, 32'h0, PC loaded on reset
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global stall; low freezes all state, outputs hold
- icache_req_out  output  1  fetch request, level, held until ack
- icache_addr_out  output  32  fetch address; stable while req high
- icache_ack_in  input  1  one-cycle ack; data valid same cycle
- icache_inst_in  input  32  fetched instruction
- pred_pc_out  output  32  current fetch PC to predictor (combinational from PC register)
- pred_next_pc_in  input  32  predicted next PC (combinational from predictor)
- pred_taken_in  input  1  predicted-taken flag
- inst_valid_out  output  1  queue head valid
- inst_out  output  32  head instruction
- inst_pc_out  output  32  head PC
- inst_pred_taken_out  output  1  head predicted-taken bit
- inst_ready_in  input  1  decoder accepts head this cycle
- flush_in  input  1  redirect; highest priority
- flush_pc_in  input  32  redirect target

## Operation
- FSM states: IDLE, WAIT (request outstanding), DROP (outstanding request to be discarded).
- IDLE: if count < QUEUE_DEPTH, then req←1, addr←pc, →WAIT.
- WAIT, ack: push {icache_inst_in, addr, pred_taken_in}; pc←pred_next_pc_in.
  - If count_next < QUEUE_DEPTH: req stays 1, addr←pred_next_pc_in, stay WAIT (back-to-back).
  - Otherwise: req←0, →IDLE.
- count_next = count + push − pop. Pop occurs when inst_valid_out && inst_ready_in.
- At most one request is ever outstanding. The queue can never overflow, because a request is launched only when space exists and only pops happen while waiting.
- flush_in, with priority over all else:
  - Queue emptied; pc←flush_pc_in.
  - IDLE: stays IDLE.
  - WAIT without ack: →DROP. Req stays high at the old address, per cache protocol.
  - WAIT with ack the same cycle: instruction discarded, req←0, →IDLE.
  - DROP: pc updated and state stays DROP.
- DROP, ack: data discarded, req←0, →IDLE.
- Simultaneous pop with flush: the flush wins and the pop has no effect.
- inst_valid_out = (count != 0). The head fields are the queue[head] registers.
- PC arithmetic is 32-bit modulo; wrap from 32'hFFFFFFFC to 0 is silent.

## Timing
- Reset values: pc=RESET_PC, state IDLE, icache_req_out=0, icache_addr_out=0, queue empty, inst_valid_out=0, inst_pc_out=0, inst_out=0, inst_pred_taken_out=0.
- First request is asserted the cycle after reset deasserts.
- Latency from ack to inst_valid_out: 1 cycle, because the push is registered.
- Steady-state throughput is 1 instruction/cycle when the cache acks every cycle and decode pops every cycle.
- The cycle after flush, req shows either the new PC (from IDLE, one cycle later) or the held old address (DROP).
- rdy_in=0: no state change, including pointers and PC. Acks arriving while rdy_in=0 are the cache's responsibility to hold.
- Reset asserted mid-request clears everything at once. The cache is required to be reset by the same signal.

## Configuration
- FETCH_PREDICT_EN defined: next PC = pred_next_pc_in; the predicted-taken bit is stored per entry.
- FETCH_PREDICT_EN undefined: next PC = addr+4; inst_pred_taken_out is always 0. pred_next_pc_in and pred_taken_in are ignored, and pred_pc_out is still driven.

## Structure
- Shared defines header: AddressBus, InstBus, RESET_PC default, FSM state encodings.
- Sub-module fetch_queue: circular buffer with head/tail pointers of log2(QUEUE_DEPTH)+1 bits, push/pop/flush, count, full/empty.

## Test plan
- Reset, cache acks each cycle, predictor returns pc+4, decode always ready -> addresses 0,4,8,12 on consecutive cycles; inst_pc_out follows one cycle behind each ack.
- Decode never ready, QUEUE_DEPTH=4 -> exactly 4 acks accepted, then req=0; one pop -> req reasserts with addr 16 the next cycle.
- Predictor returns next=0x100, taken=1 at pc 0x8 -> request after 0x8 goes to 0x100; entry 0x8 has inst_pred_taken_out=1 (0 with macro undefined, next=0xC).
- flush_in with flush_pc_in=0x200 while WAIT and no ack -> queue empty, DROP; the later ack is dropped, and the next request is addr 0x200.
- flush_in coincident with ack and pop -> nothing pushed, no pop effect, inst_valid_out=0 next cycle, next request is 0x200.
- rdy_in low for 3 cycles mid-stream -> all outputs and pointers unchanged; resumes identically.
